// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// clocks out one command byte with odd parity on device clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       we,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       clk_fall;
  logic       in_window;

  // Synchronizers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_fall  = clk_prev & ~clk_sync[1];
  assign in_window = (state == S_REQ) || (state == S_SHIFT) ||
                     (state == S_ACK) || (state == S_WAIT_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      frame        <= '0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_window && tmo_cnt == TMO_LAST) begin
        // Device stalled somewhere after the request: abandon the frame.
        ps2_clk_low  <= 1'b0;
        ps2_data_low <= 1'b0;
        ack_err      <= 1'b1;
        done         <= 1'b1;
        busy         <= 1'b0;
        state        <= S_IDLE;
      end else begin
        if (in_window) tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            if (we) begin
              frame        <= {1'b1, ~^data, data};
              ack_err      <= 1'b0;
              busy         <= 1'b1;
              ps2_clk_low  <= 1'b1;
              ps2_data_low <= (INHIBIT_CYCLES == 1);
              inh_cnt      <= '0;
              state        <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_clk_low <= 1'b0;
              tmo_cnt     <= '0;
              state       <= S_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
              // Start bit joins the final inhibit cycle.
              if (inh_cnt == INH_PRE) ps2_data_low <= 1'b1;
            end
          end
          S_REQ: begin
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
          S_SHIFT: begin
            if (clk_fall) begin
              ps2_data_low <= ~frame[0];
              frame        <= {1'b1, frame[9:1]};
              bit_cnt      <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= S_ACK;
            end
          end
          S_ACK: begin
            if (clk_fall) begin
              ack_err <= data_sync[1];
              state   <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector device model clocks the frame out,
// captured bits are checked against a parity model, plus timeout/reset/ignored-write cases.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 3000;
  localparam int HALF = 20;
  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int NVEC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       we;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pin_clk;
  logic       pin_data;
  logic       ps2_clk_low, ps2_data_low, busy, done, ack_err;

  int checks = 0;
  int errors = 0;
  int busy_drops = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    int         mode;
    logic [9:0] frame;
    logic       err;
  } vec_t;

  vec_t vecs[NVEC];

  assign pin_clk  = ~(ps2_clk_low | dev_clk_low);
  assign pin_data = ~(ps2_data_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .we           (we),
    .ps2_clk_in   (pin_clk),
    .ps2_data_in  (pin_data),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .busy         (busy),
    .done         (done),
    .ack_err      (ack_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as the device should read it: data LSB-first, odd parity, stop=1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic start_xfer(input logic [7:0] d);
    busy_drops = 0;
    @(negedge clk);
    data = d;
    we   = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check("busy_rise", busy, 1);
    check("clk_low_rise", ps2_clk_low, 1);
  endtask

  // Ends on the negedge of the first cycle with the clock released (the REQ cycle).
  task automatic inhibit_phase();
    int cnt = 0;
    int first_dl = -1;
    while (ps2_clk_low && cnt < INH + 20) begin
      if (ps2_data_low && first_dl < 0) first_dl = cnt;
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("start_overlap", first_dl, INH - 1);
    check("req_clk_released", ps2_clk_low, 0);
    check("req_data_low", ps2_data_low, 1);
  endtask

  task automatic dev_wait(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!busy) busy_drops++;
    end
  endtask

  task automatic device(input int mode, input int nclk, input int inject, output logic [9:0] got);
    got = '0;
    if (mode == M_SILENT) return;
    dev_wait(10);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && mode == M_ACK) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (!busy) busy_drops++;
        we = (i == inject && c == 4);
        if (we) data = 8'h11;
      end
      dev_clk_low = 1'b0;
      if (i < 10) got[i] = pin_data;
      if (i == 10) begin
        if (mode == M_ACK) begin
          dev_wait(5);
          dev_data_low = 1'b0;
        end
        return;
      end
      dev_wait(HALF);
    end
  endtask

  task automatic wait_done(input logic exp_err);
    int k = 0;
    while (!done && k < 200) begin
      if (!busy) busy_drops++;
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    check("busy_fall_with_done", busy, 0);
    check("ack_err", ack_err, exp_err);
    check("busy_held", busy_drops, 0);
    @(negedge clk);
    check("done_single", done, 0);
    check("pulls_released", {ps2_clk_low, ps2_data_low}, 0);
    check("ack_err_hold", ack_err, exp_err);
  endtask

  task automatic run_xfer(input logic [7:0] d, input int mode, input logic [9:0] frame,
                          input logic err, input int inject);
    logic [9:0] got;
    exp_q.push_back(frame);
    start_xfer(d);
    inhibit_phase();
    device(mode, 11, inject, got);
    check("frame_bits", got, exp_q.pop_front());
    wait_done(err);
  endtask

  initial begin
    logic [9:0] got;
    int k;

    vecs[0].d = 8'hED; vecs[0].mode = M_ACK;
    vecs[1].d = 8'h00; vecs[1].mode = M_ACK;
    vecs[2].d = 8'hFF; vecs[2].mode = M_ACK;
    vecs[3].d = 8'h5A; vecs[3].mode = M_NOACK;
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].d    = 8'($urandom_range(0, 255));
      vecs[i].mode = int'($urandom_range(0, 1));
    end
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].frame = model_frame(vecs[i].d);
      vecs[i].err   = (vecs[i].mode != M_ACK);
    end

    rst  = 1'b1;
    we   = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2_clk_low, ps2_data_low, busy, done, ack_err}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NVEC; i++)
      run_xfer(vecs[i].d, vecs[i].mode, vecs[i].frame, vecs[i].err, -1);

    // Write during a transfer must not disturb the frame on the wire.
    run_xfer(8'hED, M_ACK, model_frame(8'hED), 1'b0, 3);

    // Device never clocks: done exactly TMO cycles after the REQ cycle.
    start_xfer(8'hA3);
    inhibit_phase();
    k = 0;
    while (!done && k < TMO + 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, TMO);
    check("timeout_ack_err", ack_err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_pulls", {ps2_clk_low, ps2_data_low}, 0);
    @(negedge clk);
    check("timeout_done_single", done, 0);

    // Asynchronous reset after the 4th data bit.
    start_xfer(8'hED);
    inhibit_phase();
    device(M_ACK, 4, -1, got);
    check("partial_bits", got[3:0], 4'hD);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pulls", {ps2_clk_low, ps2_data_low}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_xfer(8'hF4, M_ACK, model_frame(8'hF4), 1'b0, -1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port: it sends one command byte (for example 0xED for the LED command, or 0xFF for reset) from the CPU to the keyboard. It is the opposite direction of `ps2_controller`, which only receives scan codes. It sits beside `ps2_controller` on the same `ps2_clk`/`ps2_data` pins and drives them open-collector through pull-low enables. The MIO bus writes the byte and polls `busy`/`done`/`ack_err`.

## Interface
- `INHIBIT_CYCLES`, default 10000, number of `clk` cycles the host holds PS/2 clock low before the start bit (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000, maximum `clk` cycles from clock release to ACK before the transfer aborts (20 ms).
- `clk`, input, 1, system clock (100 MHz). One clock domain.
- `rst`, input, 1, reset; asynchronous, active-high.
- `data`, input, 8, command byte; sampled on an accepted `we`.
- `we`, input, 1, start request; accepted only in IDLE.
- `ps2_clk_in`, input, 1, raw PS/2 clock pin level.
- `ps2_data_in`, input, 1, raw PS/2 data pin level.
- `ps2_clk_low`, output, 1, 1 means pull the clock pin to 0; 0 means release it (pin pulled high externally).
- `ps2_data_low`, output, 1, 1 means pull the data pin to 0; 0 means release it.
- `busy`, output, 1, high from the accepted `we` until `done`; `ps2_controller` ignores the bus while it is high.
- `done`, output, 1, one-cycle pulse when a transfer ends (success or error).
- `ack_err`, output, 1, status of the last transfer: 1 means missing or invalid ACK, or timeout. Valid from `done` until the next accepted `we`.

## Operation
- Pin inputs pass through a 2-FF synchronizer. A falling edge is detected as previous sync = 1 and current sync = 0.
- Shift register frame: {stop=1, parity, data[7:0]}. Parity is odd: `~^data`. The frame is latched at `we`.
- FSM states and transitions:
  - IDLE: all outputs 0. On `we`: latch the frame, clear `ack_err`, set `busy`, go to INHIBIT.
  - INHIBIT: `ps2_clk_low`=1 for INHIBIT_CYCLES cycles. In the last cycle also set `ps2_data_low`=1 (start bit). Go to REQ.
  - REQ: release the clock (`ps2_clk_low`=0) while holding data low. Start the timeout counter. Go to SHIFT with bit count 0.
  - SHIFT: on each falling edge, drive frame bit[count] LSB-first. For a bit of 0, `ps2_data_low`=1; for 1, release. Increment count. The edge after the 10th bit (stop, released) goes to ACK.
  - ACK: on the next falling edge, sample synced data. A value of 0 is a valid ACK. A value of 1 sets `ack_err`. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock = 1 and data = 1. Then pulse `done`, clear `busy`, go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_IDLE, release both lines, set `ack_err`, pulse `done`, go to IDLE.
- A `we` while `busy` is ignored, and the latched frame is unchanged.
- Reset at any point, including mid-frame, immediately releases both lines. State goes to IDLE and all outputs return to 0. The device recovers by its own timeout; no partial frame is resumed.

## Timing
- Reset values: `ps2_clk_low`=0, `ps2_data_low`=0, `busy`=0, `done`=0, `ack_err`=0.
- `busy` rises in the cycle after `we`. `ps2_clk_low` rises in that same cycle.
- Clock pull-low lasts exactly INHIBIT_CYCLES cycles. Data pull-low overlaps the last inhibit cycle.
- Data changes 3 `clk` cycles after a pin falling edge (2 synchronizer stages + edge register). This is well inside the ≥30 µs clock-low phase.
- ACK is sampled 3 cycles after the 11th device falling edge.
- `done` is high for exactly one cycle, in the same cycle `busy` falls. `ack_err` is stable in that cycle.
- Timeout counts `clk` cycles from the REQ cycle; it is not reset per bit.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Required:
  - clock held low for 10000 cycles;
  - sampled bits on the device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `done` pulses once with `ack_err`=0;
  - `busy` is high throughout.
- Send 0x00 (parity 1) and 0xFF (parity 1). The device reads the correct odd parity, and the stop bit reads 1 on the line in both cases.
- Device sends 11 clocks but leaves data high at the ACK edge. Required: `done` pulses with `ack_err`=1, and both pull-low outputs are 0 afterward.
- Device never clocks after the request. Required: `done` and `ack_err`=1 exactly TIMEOUT_CYCLES after REQ, with both lines released.
- Assert `rst` after the 4th data bit. Required: both pull-lows are 0 and `busy`=0 immediately (asynchronous). A following `we` with 0xF4 completes normally.
- Pulse `we` with 0x11 mid-transfer of 0xED. Required: the 0x11 is ignored and the frame on the wire is still 0xED.
